// File: rtl/alu_cmd_sequencer.sv
// Purpose : decodes 16-bit instructions and drives the ALU command strobes; returns dout on READ.
// Latency : 2+ALU_LAT cycles per LOAD/EXEC/INC/CLR/READ; 1 cycle per NOP/HALT/illegal.
// Backpress: instr_ready only in IDLE; a READ result is held on res_* until res_ready.
//
// Ports: Clk/RSTn (async active-low); instr/instr_valid/instr_ready in; resume leaves HALTED;
//        BusOut/Wen/INC/RST/alu_op to ALU, dout from ALU; res_data/res_valid/res_ready out;
//        halted, sticky illegal, retired_cnt (live only with SEQ_RETIRE_CNT_EN defined).
module alu_cmd_sequencer #(
    parameter int DW      = 8,
    parameter int ALU_LAT = 1
) (
    input  logic          Clk,
    input  logic          RSTn,
    input  logic [15:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          resume,
    output logic [DW-1:0] BusOut,
    output logic          Wen,
    output logic          INC,
    output logic          RST,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] dout,
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          halted,
    output logic          illegal,
    output logic [15:0]   retired_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT, S_HALTED} state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_EXEC = 4'd2;
    localparam logic [3:0] OP_INC  = 4'd3;
    localparam logic [3:0] OP_CLR  = 4'd4;
    localparam logic [3:0] OP_READ = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;
    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [DW-1:0]   bus_q, bus_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [DW-1:0]   res_data_q, res_data_d;
    logic            res_valid_q, res_valid_d;
    logic            illegal_q, illegal_d;
    logic            instr_ready_q, instr_ready_d;
    logic            retire;
    logic [DW-1:0]   imm_ext;

    assign imm_ext = DW'(instr[7:0]);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        bus_d       = bus_q;
        alu_op_d    = alu_op_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        illegal_d   = illegal_q;
        retire      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    op_d = instr[15:12];
                    case (instr[15:12])
                        OP_NOP:  retire = 1'b1;
                        OP_HALT: begin
                            retire  = 1'b1;
                            state_d = S_HALTED;
                        end
                        OP_LOAD: begin
                            bus_d   = imm_ext;
                            state_d = S_ISSUE;
                        end
                        OP_EXEC: begin
                            bus_d    = imm_ext;
                            alu_op_d = instr[10:8];
                            state_d  = S_ISSUE;
                        end
                        OP_INC, OP_CLR, OP_READ: state_d = S_ISSUE;
                        default: begin
                            illegal_d = 1'b1;
                            retire    = 1'b1;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // cnt_q==1 is the last wait cycle: dout now reflects the strobe.
                if (cnt_q == 3'd1) begin
                    retire = 1'b1;
                    if (op_q == OP_READ) begin
                        res_data_d  = dout;
                        res_valid_d = 1'b1;
                        state_d     = S_RESULT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RESULT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_HALTED: begin
                if (resume) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Registered so it stays 0 while reset is asserted and rises one edge after release.
        instr_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= S_IDLE;
            op_q          <= OP_NOP;
            bus_q         <= '0;
            alu_op_q      <= '0;
            cnt_q         <= '0;
            res_data_q    <= '0;
            res_valid_q   <= 1'b0;
            illegal_q     <= 1'b0;
            instr_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            bus_q         <= bus_d;
            alu_op_q      <= alu_op_d;
            cnt_q         <= cnt_d;
            res_data_q    <= res_data_d;
            res_valid_q   <= res_valid_d;
            illegal_q     <= illegal_d;
            instr_ready_q <= instr_ready_d;
        end
    end

    // Strobes decode the state register only, so they are single-cycle and 0 in reset.
    assign Wen         = (state_q == S_ISSUE) && (op_q == OP_LOAD);
    assign INC         = (state_q == S_ISSUE) && (op_q == OP_INC);
    assign RST         = (state_q == S_ISSUE) && (op_q == OP_CLR);
    assign BusOut      = bus_q;
    assign alu_op      = alu_op_q;
    assign res_data    = res_data_q;
    assign res_valid   = res_valid_q;
    assign instr_ready = instr_ready_q;
    assign halted      = (state_q == S_HALTED);
    assign illegal     = illegal_q;

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q;
        if (retire) retired_cnt_d = retired_cnt_q + 16'd1;
    end

    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) retired_cnt_q <= '0;
        else       retired_cnt_q <= retired_cnt_d;
    end

    assign retired_cnt = retired_cnt_q;

    logic unused_bits;
    assign unused_bits = instr[11];
`else
    assign retired_cnt = '0;

    logic unused_bits;
    assign unused_bits = ^{instr[11], retire};
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    logic        Clk = 1'b0;
    logic        RSTn = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        resume = 1'b0;
    logic [7:0]  BusOut;
    logic        Wen, INC, RST;
    logic [2:0]  alu_op;
    logic [7:0]  dout;
    logic [7:0]  res_data;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        halted, illegal;
    logic [15:0] retired_cnt;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    alu_cmd_sequencer #(.DW(8), .ALU_LAT(1)) dut (
        .Clk(Clk), .RSTn(RSTn), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .resume(resume), .BusOut(BusOut), .Wen(Wen),
        .INC(INC), .RST(RST), .alu_op(alu_op), .dout(dout), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready), .halted(halted),
        .illegal(illegal), .retired_cnt(retired_cnt)
    );

    // Simple accumulator ALU: strobe seen at an edge shows on dout right after it.
    logic [7:0] acc;
    always @(posedge Clk or negedge RSTn) begin
        if (!RSTn)    acc <= '0;
        else if (RST) acc <= '0;
        else if (Wen) acc <= BusOut;
        else if (INC) acc <= acc + 8'd1;
    end
    assign dout = acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one instruction, then counts busy cycles and strobes until the sequencer
    // is ready again, presents a result, or halts.
    task automatic run_instr(input logic [15:0] ins, output int wn, output int inn,
                             output int rn, output int busy);
        int g;
        wn = 0; inn = 0; rn = 0; busy = 0;
        @(negedge Clk);
        instr = ins;
        instr_valid = 1'b1;
        g = 0;
        while (!instr_ready && g < 20) begin
            @(negedge Clk);
            g++;
        end
        if (g >= 20) check("accept_timeout", 0, 1);
        @(posedge Clk);
        #1 instr_valid = 1'b0;
        @(negedge Clk);
        g = 0;
        while (!(instr_ready || res_valid || halted) && g < 20) begin
            wn += int'(Wen); inn += int'(INC); rn += int'(RST);
            busy++;
            @(negedge Clk);
            g++;
        end
        if (g >= 20) check("complete_timeout", 0, 1);
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!instr_ready && g < 20) begin
            @(negedge Clk);
            g++;
        end
        if (g >= 20) check("ready_timeout", 0, 1);
    endtask

    typedef struct {
        logic [15:0] ins;
        int          wen_n, inc_n, clr_n, busy;
        logic [7:0]  bus;
        logic [2:0]  op;
        logic        rv;
        logic [7:0]  res;
        logic        ill;
    } vec_t;

    vec_t vec [16];

    function automatic logic [41:0] all_outs();
        return {instr_ready, BusOut, Wen, INC, RST, alu_op, res_data, res_valid,
                halted, illegal, retired_cnt};
    endfunction

    initial begin
        int wn, inn, rn, busy, p1, p2, npulse, bad;

        vec[0]  = '{16'h0000, 0, 0, 0, 0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
        vec[1]  = '{16'h1023, 1, 0, 0, 2, 8'h23, 3'd0, 1'b0, 8'h00, 1'b0};
        vec[2]  = '{16'h5000, 0, 0, 0, 2, 8'h23, 3'd0, 1'b1, 8'h23, 1'b0};
        vec[3]  = '{16'h3000, 0, 1, 0, 2, 8'h23, 3'd0, 1'b0, 8'h00, 1'b0};
        vec[4]  = '{16'h3000, 0, 1, 0, 2, 8'h23, 3'd0, 1'b0, 8'h00, 1'b0};
        vec[5]  = '{16'h5000, 0, 0, 0, 2, 8'h23, 3'd0, 1'b1, 8'h25, 1'b0};
        vec[6]  = '{16'h2203, 0, 0, 0, 2, 8'h03, 3'd2, 1'b0, 8'h00, 1'b0};
        vec[7]  = '{16'h3000, 0, 1, 0, 2, 8'h03, 3'd2, 1'b0, 8'h00, 1'b0};
        vec[8]  = '{16'h5000, 0, 0, 0, 2, 8'h03, 3'd2, 1'b1, 8'h26, 1'b0};
        vec[9]  = '{16'h2F55, 0, 0, 0, 2, 8'h55, 3'd7, 1'b0, 8'h00, 1'b0};
        vec[10] = '{16'h4000, 0, 0, 1, 2, 8'h55, 3'd7, 1'b0, 8'h00, 1'b0};
        vec[11] = '{16'h5000, 0, 0, 0, 2, 8'h55, 3'd7, 1'b1, 8'h00, 1'b0};
        vec[12] = '{16'h10FF, 1, 0, 0, 2, 8'hFF, 3'd7, 1'b0, 8'h00, 1'b0};
        vec[13] = '{16'h5000, 0, 0, 0, 2, 8'hFF, 3'd7, 1'b1, 8'hFF, 1'b0};
        vec[14] = '{16'hF123, 0, 0, 0, 0, 8'hFF, 3'd7, 1'b0, 8'h00, 1'b1};
        vec[15] = '{16'h0000, 0, 0, 0, 0, 8'hFF, 3'd7, 1'b0, 8'h00, 1'b1};

        // Reset at time zero, then release and expect ready one edge later.
        #2 check("reset_outputs", 64'(all_outs()), 64'd0);
        @(negedge Clk);
        RSTn = 1'b1;
        @(negedge Clk);
        check("ready_after_release", 64'(instr_ready), 64'd1);

        // Reset asserted during WAIT of a READ: outputs clear, no result appears.
        instr = 16'h5000;
        instr_valid = 1'b1;
        @(posedge Clk);
        #1 instr_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        RSTn = 1'b0;
        #1 check("reset_mid_wait", 64'(all_outs()), 64'd0);
        @(negedge Clk);
        RSTn = 1'b1;
        @(negedge Clk);
        check("ready_after_midreset", 64'({instr_ready, res_valid}), 64'h2);

        // Table of single instructions.
        for (int i = 0; i < 16; i++) begin
            run_instr(vec[i].ins, wn, inn, rn, busy);
            check($sformatf("v%0d_wen", i),  64'(wn),   64'(vec[i].wen_n));
            check($sformatf("v%0d_inc", i),  64'(inn),  64'(vec[i].inc_n));
            check($sformatf("v%0d_rst", i),  64'(rn),   64'(vec[i].clr_n));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(vec[i].busy));
            check($sformatf("v%0d_bus", i),  64'(BusOut), 64'(vec[i].bus));
            check($sformatf("v%0d_op", i),   64'(alu_op), 64'(vec[i].op));
            check($sformatf("v%0d_rv", i),   64'(res_valid), 64'(vec[i].rv));
            check($sformatf("v%0d_ill", i),  64'(illegal), 64'(vec[i].ill));
            if (vec[i].rv) begin
                check($sformatf("v%0d_res", i), 64'(res_data), 64'(vec[i].res));
                repeat (2) @(negedge Clk);
                check($sformatf("v%0d_hold", i),
                      64'({res_valid, instr_ready, res_data}), 64'({2'b10, vec[i].res}));
                res_ready = 1'b1;
                @(negedge Clk);
                res_ready = 1'b0;
                check($sformatf("v%0d_accept", i), 64'({res_valid, instr_ready}), 64'h1);
            end
        end
`ifdef SEQ_RETIRE_CNT_EN
        check("retired_after_table", 64'(retired_cnt), 64'd16);
`else
        check("retired_tied_zero", 64'(retired_cnt), 64'd0);
`endif

        // Back-to-back INC with instr_valid held: pulses 3 cycles apart.
        @(negedge Clk);
        instr = 16'h3000;
        instr_valid = 1'b1;
        p1 = -1; p2 = -1; npulse = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (INC) begin
                if (npulse == 0) p1 = k;
                else if (npulse == 1) p2 = k;
                npulse++;
            end
        end
        instr_valid = 1'b0;
        check("inc_spacing", 64'(p2 - p1), 64'd3);
        check("inc_count", 64'(npulse), 64'd3);
        wait_ready();

        // HALT, then a held LOAD is refused until resume.
        run_instr(16'h6000, wn, inn, rn, busy);
        check("halted", 64'({halted, instr_ready, illegal}), 64'h5);
        @(negedge Clk);
        instr = 16'h1011;
        instr_valid = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge Clk);
            if (instr_ready || Wen || !halted) bad++;
        end
        check("halted_refuses", 64'(bad), 64'd0);
        resume = 1'b1;
        @(negedge Clk);
        resume = 1'b0;
        check("resumed", 64'({halted, instr_ready}), 64'h1);
        @(negedge Clk);
        instr_valid = 1'b0;
        check("load_after_resume", 64'({Wen, BusOut}), 64'h111);
        wait_ready();

        // resume outside HALTED has no effect.
        resume = 1'b1;
        @(negedge Clk);
        resume = 1'b0;
        @(negedge Clk);
        check("resume_ignored", 64'({halted, instr_ready}), 64'h1);

        // res_ready already high when res_valid rises: one cycle in RESULT.
        res_ready = 1'b1;
        run_instr(16'h5000, wn, inn, rn, busy);
        check("early_ready_rv", 64'({res_valid, res_data}), 64'h111);
        @(negedge Clk);
        check("early_ready_done", 64'({res_valid, instr_ready}), 64'h1);
        res_ready = 1'b0;

`ifdef SEQ_RETIRE_CNT_EN
        RSTn = 1'b0;
        @(negedge Clk);
        RSTn = 1'b1;
        @(negedge Clk);
        res_ready = 1'b1;
        run_instr(16'h0000, wn, inn, rn, busy);
        run_instr(16'h1001, wn, inn, rn, busy);
        run_instr(16'h5000, wn, inn, rn, busy);
        run_instr(16'h6000, wn, inn, rn, busy);
        res_ready = 1'b0;
        check("retired_4", 64'(retired_cnt), 64'd4);

        RSTn = 1'b0;
        @(negedge Clk);
        RSTn = 1'b1;
        @(negedge Clk);
        instr = 16'h0000;
        instr_valid = 1'b1;
        repeat (65535) @(negedge Clk);
        check("retired_ffff", 64'(retired_cnt), 64'hFFFF);
        @(negedge Clk);
        instr_valid = 1'b0;
        check("retired_wrap", 64'(retired_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
